// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues word reads
// and buffers returned instructions with their PCs in a prefetch FIFO.
module ifetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_ready,
  input  logic [31:0] mem_ins,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    BOOT,
    RUN
  } state_t;

  state_t        state;
  logic [31:0]   fpc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];
  logic          push;
  logic          pop;

  assign if_valid = (count != '0);
  assign pop      = if_valid & if_ready;
  assign mem_read = (state == RUN) & ~redirect
                  & ((count != FULL) | pop);
  assign push     = mem_read & mem_ready;
  assign mem_addr = fpc;
  assign if_pc    = pc_mem[rd_ptr];
  assign if_ins   = ins_mem[rd_ptr];

  // Boot sequencing and sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      misalign <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN:  state <= RUN;
      endcase
      if (redirect && redirect_pc[1:0] != 2'b00)
        misalign <= 1'b1;
    end
  end

  // Fetch PC, FIFO pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc    <= {BOOT_ADDR[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      fpc    <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        fpc    <= fpc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO storage; contents are only meaningful below count
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fpc;
      ins_mem[wr_ptr] <= mem_ins;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ifetch_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_ready;
  logic [31:0] mem_ins;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic        misalign;

  ifetch_ctrl #(.DEPTH(DEPTH), .BOOT_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_ready(mem_ready), .mem_ins(mem_ins),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_ins(if_ins), .if_pc(if_pc), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign mem_ins = word(mem_addr);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  bit          m_run = 0;
  logic [31:0] m_fpc = 32'h0;
  bit          m_mis = 0;
  logic [31:0] got_pc[$];

  // Reference model: FIFO as a queue, advanced on each clock edge
  always @(posedge clk or negedge rst_n) begin
    bit p, rd;
    if (!rst_n) begin
      mq.delete();
      m_run = 0;
      m_fpc = 32'h0;
      m_mis = 0;
    end else begin
      p  = (mq.size() != 0) && if_ready;
      rd = m_run && !redirect && (mq.size() < DEPTH || p);
      if (redirect) begin
        mq.delete();
        m_fpc = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) m_mis = 1;
      end else begin
        if (p) void'(mq.pop_front());
        if (rd && mem_ready) begin
          mq.push_back('{m_fpc, word(m_fpc)});
          m_fpc = m_fpc + 32'd4;
        end
      end
      m_run = 1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    bit ev, ep, er;
    #2;
    ev = (mq.size() != 0);
    ep = ev && if_ready;
    er = m_run && !redirect && (mq.size() < DEPTH || ep);
    chk("m_valid", {31'b0, if_valid}, {31'b0, ev});
    chk("m_read", {31'b0, mem_read}, {31'b0, er});
    chk("m_addr", mem_addr, m_fpc);
    chk("m_misalign", {31'b0, misalign}, {31'b0, m_mis});
    if (ev) begin
      chk("m_pc", if_pc, mq[0].pc);
      chk("m_ins", if_ins, mq[0].ins);
    end
    if (rst_n && if_valid && if_ready && !redirect)
      got_pc.push_back(if_pc);
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    if_ready    = 1'b1;
    mem_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // reset state
    repeat (2) nxt();
    #4;
    chk("rst_read", {31'b0, mem_read}, 32'd0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);

    // boot, zero-wait, streaming
    nxt(); rst_n = 1'b1;
    nxt(); #4;
    chk("c1_read", {31'b0, mem_read}, 32'd1);
    chk("c1_addr", mem_addr, 32'h0);
    chk("c1_valid", {31'b0, if_valid}, 32'd0);
    nxt(); #4;
    chk("c2_valid", {31'b0, if_valid}, 32'd1);
    chk("c2_pc", if_pc, 32'h0);
    chk("c2_ins", if_ins, 32'h1000_0000);
    nxt(); #4;
    chk("c3_pc", if_pc, 32'h4);
    chk("c3_ins", if_ins, 32'h1000_0001);
    repeat (6) nxt();
    #4;
    chk("stream_n", got_pc.size(), 32'd8);
    for (int k = 0; k < 8; k++)
      chk("stream_pc", got_pc[k], 32'(4 * k));

    // async reset mid-stream, then backpressure from boot
    nxt(); #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_read", {31'b0, mem_read}, 32'd0);
    if_ready = 1'b0;
    nxt(); rst_n = 1'b1; got_pc.delete();
    repeat (5) nxt();
    #4;
    chk("bp_read", {31'b0, mem_read}, 32'd0);
    chk("bp_addr", mem_addr, 32'h10);
    chk("bp_valid", {31'b0, if_valid}, 32'd1);
    chk("bp_head", if_pc, 32'h0);
    nxt(); if_ready = 1'b1;
    #4;
    chk("bp_pushpop", {31'b0, mem_read}, 32'd1);
    repeat (5) nxt();
    #4;
    for (int k = 0; k < 5; k++)
      chk("bp_order", got_pc[k], 32'(4 * k));

    // wait states, alternating mem_ready
    nxt(); redirect = 1'b1; redirect_pc = 32'h100; got_pc.delete();
    nxt(); redirect = 1'b0; mem_ready = 1'b0;
    #4;
    chk("ws_addr", mem_addr, 32'h100);
    chk("ws_valid", {31'b0, if_valid}, 32'd0);
    chk("ws_read", {31'b0, mem_read}, 32'd1);
    for (int i = 2; i <= 12; i++) begin
      nxt();
      mem_ready = (i % 2 == 0);
      if (!mem_ready) begin
        #4;
        chk("ws_hold", mem_addr, 32'h100 + 32'(4 * ((i - 1) / 2)));
      end
    end
    #4;
    chk("ws_n", got_pc.size(), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("ws_pc", got_pc[k], 32'h100 + 32'(4 * k));

    // redirect with 3 entries buffered and a pop presented
    nxt(); redirect = 1'b1; redirect_pc = 32'h200;
    if_ready = 1'b0; mem_ready = 1'b1;
    nxt(); redirect = 1'b0;
    nxt();
    nxt();
    nxt(); redirect = 1'b1; redirect_pc = 32'h40;
    if_ready = 1'b1; got_pc.delete();
    #4;
    chk("rd_valid3", {31'b0, if_valid}, 32'd1);
    chk("rd_head3", if_pc, 32'h200);
    nxt(); redirect = 1'b0;
    #4;
    chk("rd_valid", {31'b0, if_valid}, 32'd0);
    chk("rd_addr", mem_addr, 32'h40);
    chk("rd_read", {31'b0, mem_read}, 32'd1);
    repeat (4) nxt();
    #4;
    chk("rd_n", got_pc.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("rd_pc", got_pc[k], 32'h40 + 32'(4 * k));

    // misaligned redirect, sticky
    nxt(); redirect = 1'b1; redirect_pc = 32'h42;
    nxt(); redirect = 1'b0;
    #4;
    chk("mis_set", {31'b0, misalign}, 32'd1);
    chk("mis_addr", mem_addr, 32'h40);
    nxt(); redirect = 1'b1; redirect_pc = 32'h80;
    nxt(); redirect = 1'b0;
    #4;
    chk("mis_sticky", {31'b0, misalign}, 32'd1);
    chk("mis_addr2", mem_addr, 32'h80);

    // PC wrap, then reset mid-stream and restart
    nxt(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; got_pc.delete();
    nxt(); redirect = 1'b0;
    repeat (3) nxt();
    #4;
    chk("wrap_n", got_pc.size(), 32'd3);
    chk("wrap_pc0", got_pc[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", got_pc[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", got_pc[2], 32'h0000_0000);
    nxt(); #1 rst_n = 1'b0;
    #1;
    chk("rst2_valid", {31'b0, if_valid}, 32'd0);
    chk("rst2_read", {31'b0, mem_read}, 32'd0);
    chk("rst2_mis", {31'b0, misalign}, 32'd0);
    nxt(); rst_n = 1'b1;
    nxt(); #4;
    chk("rs_read", {31'b0, mem_read}, 32'd1);
    chk("rs_addr", mem_addr, 32'h0);
    nxt(); #4;
    chk("rs_valid", {31'b0, if_valid}, 32'd1);
    chk("rs_pc", if_pc, 32'h0);

    nxt(); #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller between the pipeline IF stage and the instruction memory. It owns the fetch PC and issues word reads over the memory's `read`/`ready` handshake. Returned instructions are buffered with their PCs in a small prefetch FIFO. The decode stage drains the FIFO through a valid/ready interface, and a redirect from a branch or jump flushes the FIFO and restarts fetch.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2
- `BOOT_ADDR`, 32'h0000_0000: fetch PC after reset
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `mem_addr` out 32: byte address to instruction memory; always equals fetch PC
- `mem_read` out 1: read request
- `mem_ready` in 1: memory data valid this cycle; sampled only while `mem_read`=1
- `mem_ins` in 32: instruction word from memory
- `redirect` in 1: flush and restart fetch
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored
- `if_valid` out 1: FIFO head valid
- `if_ready` in 1: consumer accepts head
- `if_ins` out 32: head instruction
- `if_pc` out 32: head PC
- `misalign` out 1: sticky; set when a redirect arrives with `redirect_pc[1:0]`≠0

## Operation
- States:
  - BOOT: entered on reset; no reads issued. Unconditionally goes to RUN on the first clock edge after `rst_n` deasserts.
  - RUN: normal fetching.
- Fetch PC register `fpc`, resets to `{BOOT_ADDR[31:2],2'b00}`.
- `mem_read` = RUN & !`redirect` & (`count`<DEPTH | pop). This is combinational from registers and inputs only; it never depends on `mem_ready`.
- push = `mem_read` & `mem_ready`.
  - On push: write {`fpc`, `mem_ins`} at the write pointer.
  - `fpc` <= `fpc`+4, mod 2^32 (wraps from 32'hFFFF_FFFC to 0).
- pop = `if_valid` & `if_ready`; advances the read pointer.
- `count` += push − pop. Simultaneous push and pop on a full FIFO is legal, and `count` stays at DEPTH.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- Redirect has priority over push and pop in the same cycle:
  - Pointers and `count` reset to 0.
  - `fpc` <= {`redirect_pc`[31:2],2'b00}.
  - No push occurs, since `mem_read`=0.
  - A pop presented that cycle is discarded; the consumer must ignore the head it saw in the redirect cycle.
- `misalign` is set on redirect with a nonzero low address field and is cleared only by reset.
- `if_valid` = (`count`≠0). `if_ins` and `if_pc` are driven from the head entry and are stable while `if_valid`=1 and no pop occurs.
- When `mem_ready`=0 with `mem_read`=1, hold `mem_addr` and retry every cycle. No timeout.

## Timing
- Reset values:
  - `mem_read`=0, `mem_addr`=BOOT_ADDR, `if_valid`=0, `misalign`=0.
  - `if_ins`/`if_pc` = don't-care while `if_valid`=0; the bench must not check them.
- Cycle 0 is the first edge after reset release: BOOT→RUN.
- Cycle 1: `mem_read`=1 with `mem_addr`=BOOT_ADDR.
- With a zero-wait memory (`mem_ready`=1), the first push happens at the end of cycle 1, and `if_valid`=1 from cycle 2.
- Fetch-to-visible latency is 1 cycle after push.
- Steady state with zero-wait memory and `if_ready`=1 sustains 1 instruction per cycle.
- After a redirect in cycle N:
  - Cycle N+1: `if_valid`=0 and `mem_read`=1 at the new PC.
  - First new instruction visible at N+2.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values; FIFO contents are discarded.

## Test plan
- Boot, zero-wait memory, `if_ready`=1, memory holds word k = 32'h1000_0000+k: `if_valid` rises at cycle 2. Sequence is pc 0,4,8,… with ins 1000_0000,1000_0001,…, one per cycle and no gaps.
- Backpressure: hold `if_ready`=0 from boot. Exactly 4 pushes occur, then `mem_read`=0 with `mem_addr`=0x10 and the head stays at pc 0. Release `if_ready`: pop and push occur in the same cycle, and the order is preserved.
- Wait states: `mem_ready` alternates 0/1. `mem_addr` is held during each 0 cycle, no duplicate or missing PCs appear, and throughput is 1 instruction per 2 cycles.
- Redirect to 0x40 while the FIFO holds 3 entries and `if_ready`=1 in the same cycle: next cycle `if_valid`=0 and `mem_addr`=0x40. The next output is pc 0x40, and no stale PC is ever output.
- Redirect to 0x42: `misalign`=1 (sticky through later redirects), and fetch resumes at 0x40.
- Wrap and reset: redirect to 0xFFFF_FFF8 with zero-wait memory gives pcs FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting `rst_n`=0 mid-stream makes `if_valid`=0 and `mem_read`=0 immediately; after release, fetch restarts at BOOT_ADDR.
